// File: rtl/cipher_char_buffer_if.sv
// rtl/cipher_char_buffer_if.sv - handshake/status bundle between encryption stage, buffer and transmit side
//
// Purpose: groups the ciphertext write side, the valid/ready read side and the
// status outputs of cipher_char_buffer into one interface.
// Signals:
//   C_ready, Char_ciphertext, msg_end   - byte write qualifier, byte, end-of-message mark
//   err_invalid_ptxt                    - encryption stage rejected a plaintext character
//   clear                               - synchronous flush
//   out_data, out_last, out_valid       - FIFO head presented to the consumer
//   out_ready                           - consumer accepts the head
//   full, empty, count, msg_len         - occupancy and message-length status
//   overflow_err, ptxt_err              - sticky error flags
// Modports: slave = buffer view, master = producer/consumer view.

interface cipher_char_buffer_if #(
    parameter int ADDR_W = 4
) ();
    logic              C_ready;
    logic [7:0]        Char_ciphertext;
    logic              err_invalid_ptxt;
    logic              msg_end;
    logic              clear;
    logic [7:0]        out_data;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic [7:0]        msg_len;
    logic              overflow_err;
    logic              ptxt_err;

    modport slave (
        input  C_ready, Char_ciphertext, err_invalid_ptxt, msg_end, clear, out_ready,
        output out_data, out_last, out_valid, full, empty, count, msg_len,
               overflow_err, ptxt_err
    );

    modport master (
        output C_ready, Char_ciphertext, err_invalid_ptxt, msg_end, clear, out_ready,
        input  out_data, out_last, out_valid, full, empty, count, msg_len,
               overflow_err, ptxt_err
    );
endinterface

// File: rtl/cipher_char_buffer.sv
// rtl/cipher_char_buffer.sv - FWFT ciphertext byte FIFO with message framing and sticky error flags
//
// Purpose: captures each ciphertext byte qualified by C_ready into a
// first-word-fall-through FIFO of {last, byte} entries, counts bytes of the
// current message, records dropped bytes and rejected plaintext, and streams
// the bytes out over a valid/ready handshake.
// Ports:
//   clk    - system clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - cipher_char_buffer_if.slave (write side, read side, status)

module cipher_char_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cipher_char_buffer_if.slave   bus
);

    localparam logic [ADDR_W:0]   LP_FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LP_CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] LP_PTR_ONE  = ADDR_W'(1);

    logic [8:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [7:0]        r_msg_len;
    logic              r_overflow_err;
    logic              r_ptxt_err;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_drop;
    logic [8:0]        w_head;

    // Full/empty come from the registered count only, so a write this cycle
    // can never make out_valid rise combinationally.
    assign w_full  = (r_count == LP_FULL_CNT);
    assign w_empty = (r_count == '0);

    // Flags are judged on start-of-cycle state: a read in the same cycle does
    // not free a slot for a write into a full FIFO. clear suppresses both.
    assign w_wr_en = bus.C_ready && !w_full && !bus.clear;
    assign w_rd_en = bus.out_ready && !w_empty && !bus.clear;
    assign w_drop  = bus.C_ready && w_full;

    assign w_head  = r_mem[r_rd_ptr];

    // Storage holds no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {bus.msg_end, bus.Char_ciphertext};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + LP_CNT_ONE;
            end else if (w_rd_en && !w_wr_en) begin
                r_count <= r_count - LP_CNT_ONE;
            end
        end
    end

    // Message length counts accepted bytes; the accepted last byte closes the
    // message so the next message starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg_len <= '0;
        end else if (bus.clear) begin
            r_msg_len <= '0;
        end else if (w_wr_en) begin
            if (bus.msg_end) begin
                r_msg_len <= '0;
            end else if (r_msg_len != 8'hFF) begin
                r_msg_len <= r_msg_len + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow_err <= 1'b0;
            r_ptxt_err     <= 1'b0;
        end else if (bus.clear) begin
            r_overflow_err <= 1'b0;
            r_ptxt_err     <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow_err <= 1'b1;
            end
            if (bus.err_invalid_ptxt) begin
                r_ptxt_err <= 1'b1;
            end
        end
    end

    assign bus.out_valid    = !w_empty;
    assign bus.out_data     = w_empty ? 8'h00 : w_head[7:0];
    assign bus.out_last     = w_empty ? 1'b0  : w_head[8];
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = r_count;
    assign bus.msg_len      = r_msg_len;
    assign bus.overflow_err = r_overflow_err;
    assign bus.ptxt_err     = r_ptxt_err;

endmodule

// File: tb/tb_cipher_char_buffer.sv
// tb/tb_cipher_char_buffer.sv - scoreboard bench for cipher_char_buffer

module tb_cipher_char_buffer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [8:0] sb[$];

    cipher_char_buffer_if #(.ADDR_W(4)) bus ();

    cipher_char_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic last, input logic expect_accept);
        bus.C_ready         = 1'b1;
        bus.Char_ciphertext = d;
        bus.msg_end         = last;
        if (expect_accept) sb.push_back({last, d});
        step();
        bus.C_ready = 1'b0;
        bus.msg_end = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    // Monitor: a transfer happens on the coming edge whenever valid and ready
    // are both high and no flush is pending; compare the head to the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !bus.clear) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%0h expected no transfer", bus.out_data);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                chk("out_data", {24'h0, bus.out_data}, {24'h0, e[7:0]});
                chk("out_last", {31'h0, bus.out_last}, {31'h0, e[8]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.C_ready = 1'b0;
        bus.Char_ciphertext = 8'h00;
        bus.err_invalid_ptxt = 1'b0;
        bus.msg_end = 1'b0;
        bus.clear = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset / idle state
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_msg_len", bus.msg_len, 0);
        chk("rst_overflow", bus.overflow_err, 0);
        chk("rst_ptxt", bus.ptxt_err, 0);

        // Three-byte message, then drain
        bus.C_ready = 1'b1;
        bus.Char_ciphertext = 8'h05;
        #1;
        chk("no_comb_valid", bus.out_valid, 0);
        bus.C_ready = 1'b0;
        wr(8'h05, 1'b0, 1'b1);
        chk("lat_out_valid", bus.out_valid, 1);
        chk("lat_out_data", bus.out_data, 8'h05);
        chk("msg_len_1", bus.msg_len, 1);
        wr(8'hE2, 1'b0, 1'b1);
        chk("msg_len_2", bus.msg_len, 2);
        wr(8'h7A, 1'b1, 1'b1);
        chk("msg_len_end", bus.msg_len, 0);
        chk("count_3", bus.count, 3);
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("drain_count", bus.count, 0);
        chk("drain_valid", bus.out_valid, 0);
        step();
        chk("ready_on_empty_count", bus.count, 0);
        bus.out_ready = 1'b0;

        // Fill past capacity
        for (int i = 0; i < 17; i++) begin
            wr(8'(i), 1'b0, i < 16);
            if (i == 15) chk("full_at_16", bus.full, 1);
        end
        chk("ovf_set", bus.overflow_err, 1);
        chk("ovf_count", bus.count, 16);
        bus.out_ready = 1'b1;
        repeat (16) step();
        chk("ovf_drain_empty", bus.empty, 1);
        chk("ovf_sticky", bus.overflow_err, 1);
        bus.out_ready = 1'b0;
        do_clear();
        chk("clear_ovf", bus.overflow_err, 0);

        // Full + write + read in the same cycle: read only, byte dropped
        for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i), 1'b0, 1'b1);
        bus.out_ready = 1'b1;
        wr(8'h99, 1'b0, 1'b0);
        chk("fullrw_count", bus.count, 15);
        chk("fullrw_ovf", bus.overflow_err, 1);
        repeat (15) step();
        chk("fullrw_drain_empty", bus.empty, 1);
        do_clear();

        // Streaming write+read across two pointer wraps
        wr(8'h40, 1'b0, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            wr(8'h40 + 8'(i), (i % 8) == 0, 1'b1);
            if (bus.count != 1) chk("stream_count", bus.count, 1);
        end
        chk("stream_count_end", bus.count, 1);
        step();
        chk("stream_empty", bus.empty, 1);
        bus.out_ready = 1'b0;

        // Plaintext error then clear with a coincident write
        bus.err_invalid_ptxt = 1'b1;
        step();
        bus.err_invalid_ptxt = 1'b0;
        chk("ptxt_set", bus.ptxt_err, 1);
        chk("ptxt_no_write", bus.count, 0);
        bus.clear = 1'b1;
        wr(8'h33, 1'b0, 1'b0);
        bus.clear = 1'b0;
        chk("clear_count", bus.count, 0);
        chk("clear_ptxt", bus.ptxt_err, 0);
        chk("clear_empty", bus.empty, 1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i), 1'b0, 1'b1);
        chk("pre_rst_count", bus.count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_count", bus.count, 0);
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_data", bus.out_data, 0);
        chk("arst_empty", bus.empty, 1);
        step();
        rst_n = 1'b1;
        step();
        wr(8'h44, 1'b0, 1'b1);
        chk("post_rst_data", bus.out_data, 8'h44);
        chk("post_rst_count", bus.count, 1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("final_empty", bus.empty, 1);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
